// File: rtl/cpu6_fetch.sv
// rtl/cpu6_fetch.sv - instruction fetch unit with 2-entry buffer and redirect flush
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   redirect, redirect_pc      taken branch/jump from EX and its target
//   excp_redirect, excp_pc     trap redirect and its target (wins over redirect)
//   imem_req/addr/gnt          fetch request channel to instruction memory
//   imem_rvalid/rdata          in-order response channel from instruction memory
//   out_valid/pc/instr/ready   pc/instruction pair handed to decode/EX
module cpu6_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        excp_redirect,
   input  logic [31:0] excp_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready
);

   localparam logic [2:0] DEPTH_L = 3'(DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic [1:0]  outst_q, outst_d;
   logic [1:0]  buf_count_q, buf_count_d;
   logic [1:0]  drop_q, drop_d;
   logic [31:0] b0_pc_q, b0_pc_d, b0_instr_q, b0_instr_d;
   logic [31:0] b1_pc_q, b1_pc_d, b1_instr_q, b1_instr_d;

   logic        redir_any;
   logic [31:0] target;
   logic        fire;
   logic        pop;
   logic        push;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_BOOT;
         fetch_pc_q  <= RESET_PC;
         rsp_pc_q    <= RESET_PC;
         outst_q     <= 2'd0;
         buf_count_q <= 2'd0;
         drop_q      <= 2'd0;
         b0_pc_q     <= 32'd0;
         b0_instr_q  <= 32'd0;
         b1_pc_q     <= 32'd0;
         b1_instr_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         rsp_pc_q    <= rsp_pc_d;
         outst_q     <= outst_d;
         buf_count_q <= buf_count_d;
         drop_q      <= drop_d;
         b0_pc_q     <= b0_pc_d;
         b0_instr_q  <= b0_instr_d;
         b1_pc_q     <= b1_pc_d;
         b1_instr_q  <= b1_instr_d;
      end
   end

   // Output logic
   always_comb begin
      redir_any = redirect | excp_redirect;
      target    = excp_redirect ? {excp_pc[31:2], 2'b00} : {redirect_pc[31:2], 2'b00};
      // Requests in flight plus buffered entries never exceed the buffer size,
      // so every response is guaranteed a free slot.
      imem_req  = (state_q == S_RUN) && !redir_any &&
                  (({1'b0, outst_q} + {1'b0, buf_count_q}) < DEPTH_L);
      imem_addr = {fetch_pc_q[31:2], 2'b00};
      out_valid = (buf_count_q != 2'd0);
      out_pc    = b0_pc_q;
      out_instr = b0_instr_q;
      fire      = imem_req & imem_gnt;
      pop       = out_valid & out_ready;
      push      = imem_rvalid && (drop_q == 2'd0) && !redir_any;
   end

   // Datapath and buffer next-state
   always_comb begin
      outst_d     = outst_q + {1'b0, fire} - {1'b0, imem_rvalid};
      fetch_pc_d  = fetch_pc_q;
      rsp_pc_d    = rsp_pc_q;
      drop_d      = drop_q;
      buf_count_d = buf_count_q;
      b0_pc_d     = b0_pc_q;
      b0_instr_d  = b0_instr_q;
      b1_pc_d     = b1_pc_q;
      b1_instr_d  = b1_instr_q;

      if (fire)
         fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)
         rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rvalid && (drop_q != 2'd0))
         drop_d = drop_q - 2'd1;

      // Head is always entry 0; a pop shifts entry 1 down.
      case ({push, pop})
         2'b10: begin
            if (buf_count_q == 2'd0) begin
               b0_pc_d    = rsp_pc_q;
               b0_instr_d = imem_rdata;
            end else begin
               b1_pc_d    = rsp_pc_q;
               b1_instr_d = imem_rdata;
            end
            buf_count_d = buf_count_q + 2'd1;
         end
         2'b01: begin
            b0_pc_d     = b1_pc_q;
            b0_instr_d  = b1_instr_q;
            buf_count_d = buf_count_q - 2'd1;
         end
         2'b11: begin
            if (buf_count_q == 2'd1) begin
               b0_pc_d    = rsp_pc_q;
               b0_instr_d = imem_rdata;
            end else begin
               b0_pc_d    = b1_pc_q;
               b0_instr_d = b1_instr_q;
               b1_pc_d    = rsp_pc_q;
               b1_instr_d = imem_rdata;
            end
         end
         default: ;
      endcase

      // Every request still in flight after this cycle belongs to the old path.
      if (redir_any) begin
         fetch_pc_d  = target;
         rsp_pc_d    = target;
         buf_count_d = 2'd0;
         drop_d      = outst_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   state_d = (redir_any && (drop_d != 2'd0)) ? S_FLUSH : S_RUN;
         S_FLUSH: state_d = (drop_d == 2'd0) ? S_RUN : S_FLUSH;
         default: state_d = S_BOOT;
      endcase
   end

endmodule

// File: tb/tb_cpu6_fetch.sv
// tb/tb_cpu6_fetch.sv - randomized self-checking bench for cpu6_fetch
module tb_cpu6_fetch;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        excp_redirect;
   logic [31:0] excp_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;

   cpu6_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .excp_redirect (excp_redirect),
      .excp_pc       (excp_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .out_valid     (out_valid),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
      .out_ready     (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: memory in-flight queue tagged with a path epoch,
   // plus a queue of buffered pc/instr pairs.
   int          cyc;
   logic        m_boot;
   logic [31:0] m_fetch;
   int          m_epoch;
   logic [31:0] q_addr[$];
   int          q_ep[$];
   int          q_due[$];
   logic [31:0] b_pc[$];
   logic [31:0] b_in[$];

   logic        force_r, force_e;
   logic [31:0] fix_rpc, fix_epc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] pick_target();
      case ($urandom_range(5))
         0: return 32'h0000_0200;
         1: return 32'h0000_0080;
         2: return 32'h0000_0303;
         3: return 32'hFFFF_FFF8;
         4: return 32'h0000_0100;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      reset         = 1'b1;
      redirect      = 1'b0;
      excp_redirect = 1'b0;
      redirect_pc   = 32'd0;
      excp_pc       = 32'd0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'd0;
      out_ready     = 1'b0;
      q_addr.delete(); q_ep.delete(); q_due.delete();
      b_pc.delete(); b_in.delete();
      m_fetch = 32'h0000_0100;
      m_boot  = 1'b1;
      m_epoch = 0;
      repeat (2) @(negedge clk);
      check("rst_imem_req", imem_req, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_imem_addr", imem_addr, 32'h0000_0100);
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs after a negedge, check, advance the model.
   task automatic step(input int p_r, input int p_e, input int p_rdy, input int p_g,
                       input int lo, input int hi);
      logic        r, e, rdy, g, rv, exp_req, redir;
      int          stale, ep;
      logic [31:0] a;
      r   = force_r | ($urandom_range(99) < p_r);
      e   = force_e | ($urandom_range(99) < p_e);
      rdy = ($urandom_range(99) < p_rdy);
      g   = ($urandom_range(99) < p_g);
      redirect      = r;
      excp_redirect = e;
      redirect_pc   = force_r ? fix_rpc : pick_target();
      excp_pc       = force_e ? fix_epc : pick_target();
      out_ready     = rdy;
      imem_gnt      = g;
      rv = (q_addr.size() > 0) && (q_due[0] <= cyc);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_f(q_addr[0]) : $urandom;
      #1;
      redir = r | e;
      stale = 0;
      foreach (q_ep[i]) if (q_ep[i] != m_epoch) stale++;
      exp_req = !m_boot && !redir && (stale == 0) && ((q_addr.size() + b_pc.size()) < 2);
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, m_fetch);
      check("out_valid", out_valid, b_pc.size() != 0);
      if (b_pc.size() != 0) begin
         check("out_pc", out_pc, b_pc[0]);
         check("out_instr", out_instr, b_in[0]);
      end
      if ((b_pc.size() != 0) && rdy) begin
         void'(b_pc.pop_front());
         void'(b_in.pop_front());
      end
      if (rv) begin
         a  = q_addr.pop_front();
         ep = q_ep.pop_front();
         void'(q_due.pop_front());
         if ((ep == m_epoch) && !redir) begin
            b_pc.push_back(a);
            b_in.push_back(mem_f(a));
         end
      end
      if (exp_req && g) begin
         q_addr.push_back(m_fetch);
         q_ep.push_back(m_epoch);
         q_due.push_back(cyc + int'($urandom_range(hi, lo)));
         m_fetch = m_fetch + 32'd4;
      end
      if (redir) begin
         m_epoch++;
         m_fetch = (e ? excp_pc : redirect_pc) & 32'hFFFF_FFFC;
         b_pc.delete();
         b_in.delete();
      end
      m_boot = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic forced(input logic fr, input logic [31:0] rpc, input logic fe,
                         input logic [31:0] epc, input int lo, input int hi);
      force_r = fr; fix_rpc = rpc;
      force_e = fe; fix_epc = epc;
      step(0, 0, 100, 100, lo, hi);
      force_r = 1'b0;
      force_e = 1'b0;
   endtask

   initial begin
      cyc     = 0;
      force_r = 1'b0;
      force_e = 1'b0;
      fix_rpc = 32'd0;
      fix_epc = 32'd0;
      do_reset();

      // Streaming from RESET_PC with a 1-cycle memory
      repeat (20) step(0, 0, 100, 100, 1, 1);
      // Consumer stalled, then released
      repeat (15) step(0, 0, 0, 100, 1, 1);
      repeat (15) step(0, 0, 100, 100, 1, 1);
      // Redirect with requests outstanding on a slow memory
      repeat (4) step(0, 0, 0, 100, 3, 3);
      forced(1'b1, 32'h0000_0200, 1'b0, 32'd0, 3, 3);
      repeat (15) step(0, 0, 100, 100, 1, 3);
      // Trap wins over branch
      repeat (3) step(0, 0, 100, 100, 2, 2);
      forced(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0080, 2, 2);
      repeat (12) step(0, 0, 100, 100, 1, 2);
      // Misaligned target
      forced(1'b1, 32'h0000_0303, 1'b0, 32'd0, 1, 1);
      repeat (10) step(0, 0, 100, 100, 1, 1);
      // Address wrap past 0xFFFF_FFFC
      forced(1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 1, 1);
      repeat (12) step(0, 0, 100, 100, 1, 1);
      // Randomized traffic
      repeat (3000) step(6, 3, 70, 70, 1, 3);

      // Reset asserted while flushing
      for (int i = 0; i < 20 && q_addr.size() < 2; i++) step(0, 0, 100, 100, 3, 3);
      forced(1'b1, 32'h0000_0400, 1'b0, 32'd0, 3, 3);
      #2 reset = 1'b1;
      #1;
      check("async_imem_req", imem_req, 0);
      check("async_out_valid", out_valid, 0);
      check("async_out_pc", out_pc, 0);
      check("async_out_instr", out_instr, 0);
      check("async_imem_addr", imem_addr, 32'h0000_0100);
      do_reset();
      repeat (300) step(6, 3, 70, 70, 1, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
